// File: rtl/hall_pulse_filter.sv
// hall_pulse_filter: per-channel hall input sync, glitch filter, rising-edge strobe, stall timer and optional period
// Define HALL_PERIOD_EN to build the per-channel period measurement; otherwise period_out/period_valid are tied to 0.
module hall_pulse_filter #(
    parameter int N_CHANNELS  = 6,
    parameter int FILT_CYCLES = 16,
    parameter int FILT_W      = 5,
    parameter int STALL_EXP2  = 20,
    parameter int PERIOD_W    = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_CHANNELS-1:0]          hall_in,
    output logic [N_CHANNELS-1:0]          pulse_out,
    output logic [N_CHANNELS-1:0]          edge_strobe,
    output logic [N_CHANNELS-1:0]          stall,
    output logic [N_CHANNELS*PERIOD_W-1:0] period_out,
    output logic [N_CHANNELS-1:0]          period_valid
);

    logic [N_CHANNELS-1:0] s1, s2;

    // two-flop synchroniser for the asynchronous hall inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= hall_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        logic                  filt, strobe, flip;
        logic [FILT_W-1:0]     cnt;
        logic [STALL_EXP2-1:0] tmr;

        assign flip = (s2[i] != filt) && (cnt == FILT_W'(FILT_CYCLES - 1));

        // filter accepts a new level after FILT_CYCLES consecutive disagreeing samples; stall timer restarts on each rising edge
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                filt   <= 1'b0;
                strobe <= 1'b0;
                tmr    <= '0;
            end else begin
                cnt    <= (s2[i] == filt || flip) ? '0 : cnt + 1'b1;
                filt   <= flip ? s2[i] : filt;
                strobe <= flip & s2[i];
                tmr    <= strobe ? '0 : (&tmr) ? tmr : tmr + 1'b1;
            end
        end

        assign pulse_out[i]   = filt;
        assign edge_strobe[i] = strobe;
        assign stall[i]       = &tmr;

`ifdef HALL_PERIOD_EN
        logic [PERIOD_W-1:0] pcnt, per;
        logic                armed, valid;

        // period counter is re-armed by every strobe; a stall invalidates history so two fresh edges are needed
        always_ff @(posedge clk) begin
            if (reset) begin
                pcnt  <= '0;
                per   <= '0;
                armed <= 1'b0;
                valid <= 1'b0;
            end else begin
                pcnt  <= strobe ? PERIOD_W'(1) : (&pcnt) ? pcnt : pcnt + 1'b1;
                per   <= strobe ? pcnt : per;
                armed <= strobe | (armed & ~stall[i]);
                valid <= strobe ? (armed & ~stall[i]) : (valid & ~stall[i]);
            end
        end

        assign period_out[i*PERIOD_W +: PERIOD_W] = per;
        assign period_valid[i]                    = valid;
`else
        assign period_out[i*PERIOD_W +: PERIOD_W] = '0;
        assign period_valid[i]                    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_hall_pulse_filter.sv
// tb_hall_pulse_filter: scoreboard bench; expected strobe cycles are queued at stimulus time and matched by a monitor
module tb_hall_pulse_filter;
    localparam int N  = 6;
    localparam int FC = 16;
    localparam int SE = 11;
    localparam int PW = 24;
    localparam int LAT = FC + 2;
    localparam int STALL_T = (1 << SE) - 1;
`ifdef HALL_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    hall_in = '0;
    logic [N-1:0]    pulse_out, edge_strobe, stall, period_valid;
    logic [N*PW-1:0] period_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_q [N][$];

    hall_pulse_filter #(
        .N_CHANNELS(N), .FILT_CYCLES(FC), .FILT_W(5), .STALL_EXP2(SE), .PERIOD_W(PW)
    ) dut (
        .clk(clk), .reset(reset), .hall_in(hall_in), .pulse_out(pulse_out),
        .edge_strobe(edge_strobe), .stall(stall), .period_out(period_out), .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    function automatic logic [31:0] per(input int ch);
        return 32'(period_out[ch*PW +: PW]);
    endfunction

    // monitor: every observed strobe must match the next queued expected cycle for its channel
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (edge_strobe[i]) begin
                if (exp_q[i].size() == 0) check($sformatf("strobe_unexp_ch%0d", i), 32'(cyc), 32'hffff_ffff);
                else check($sformatf("strobe_cyc_ch%0d", i), 32'(cyc), 32'(exp_q[i].pop_front()));
            end
        end
    end

    initial begin
        int r, c, c0;
        step(2);
        reset = 1'b0;
        r = cyc;
        check("rst_pulse", 32'(pulse_out), 0);
        check("rst_strobe", 32'(edge_strobe), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_pvalid", 32'(period_valid), 0);
        check("rst_period", 32'(period_out[31:0]), 0);

        wait_until(r + 100);
        check("idle_pulse", 32'(pulse_out), 0);
        check("idle_strobe", 32'(edge_strobe), 0);
        check("idle_stall", 32'(stall), 0);
        check("idle_pvalid", 32'(period_valid), 0);

        wait_until(r + STALL_T - 1);
        check("stall_pre", 32'(stall), 0);
        step();
        check("stall_on", 32'(stall), 32'h3f);

        c = cyc;
        hall_in[1] = 1'b1;
        exp_q[1].push_back(c + LAT);
        wait_until(c + LAT);
        check("ch1_strobe", 32'(edge_strobe), 32'h02);
        check("ch1_stall_hold", 32'(stall), 32'h3f);
        step();
        check("ch1_stall_drop", 32'(stall), 32'h3d);
        check("ch1_strobe_end", 32'(edge_strobe), 0);
        hall_in[1] = 1'b0;
        step(30);

        c = cyc;
        hall_in[0] = 1'b1;
        exp_q[0].push_back(c + LAT);
        wait_until(c + LAT - 1);
        check("ch0_pre", 32'(pulse_out[0]), 0);
        step();
        check("ch0_rise", 32'(pulse_out[0]), 1);
        check("ch0_strobe", 32'(edge_strobe[0]), 1);
        step();
        check("ch0_strobe_1cyc", 32'(edge_strobe[0]), 0);
        check("ch0_level", 32'(pulse_out[0]), 1);
        hall_in[0] = 1'b0;
        step(30);
        check("ch0_fall", 32'(pulse_out[0]), 0);

        hall_in[2] = 1'b1;
        step(FC - 1);
        hall_in[2] = 1'b0;
        step(5);
        hall_in[2] = 1'b1;
        step(FC - 1);
        hall_in[2] = 1'b0;
        step(25);
        check("ch2_glitch", 32'(pulse_out[2]), 0);
        c = cyc;
        hall_in[2] = 1'b1;
        exp_q[2].push_back(c + LAT);
        step(FC);
        hall_in[2] = 1'b0;
        wait_until(c + LAT);
        check("ch2_accept", 32'(pulse_out[2]), 1);
        step(30);

        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            c = c0 + (k == 0 ? 0 : k == 1 ? 1000 : 2500);
            wait_until(c);
            hall_in[3] = 1'b1;
            exp_q[3].push_back(c + LAT);
            step(100);
            hall_in[3] = 1'b0;
            wait_until(c + LAT + 1);
            check($sformatf("ch3_pvalid_%0d", k), 32'(period_valid[3]), (k == 0) ? 0 : 32'(PEN));
            if (k > 0) check($sformatf("ch3_period_%0d", k), per(3), PEN ? ((k == 1) ? 1000 : 1500) : 0);
        end
        for (int k = 0; k < 3000 && !stall[3]; k++) step();
        check("ch3_stall_rise", 32'(stall[3]), 1);
        step();
        check("ch3_pvalid_clr", 32'(period_valid[3]), 0);
        check("ch3_period_hold", per(3), PEN ? 1500 : 0);

        c = cyc;
        hall_in[0] = 1'b1;
        hall_in[5] = 1'b1;
        exp_q[0].push_back(c + LAT);
        exp_q[5].push_back(c + LAT);
        wait_until(c + LAT);
        check("ch05_strobes", 32'(edge_strobe), 32'h21);
        hall_in[0] = 1'b0;
        hall_in[5] = 1'b0;
        step(40);

        hall_in[4] = 1'b1;
        step(10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        r = cyc;
        check("rst2_pulse", 32'(pulse_out), 0);
        check("rst2_stall", 32'(stall), 0);
        exp_q[4].push_back(r + LAT);
        wait_until(r + LAT - 1);
        check("ch4_pre", 32'(pulse_out[4]), 0);
        step();
        check("ch4_strobe", 32'(edge_strobe), 32'h10);
        check("ch4_rise", 32'(pulse_out[4]), 1);
        hall_in[4] = 1'b0;
        step(30);

        for (int i = 0; i < N; i++) check($sformatf("strobe_missing_ch%0d", i), 32'(exp_q[i].size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
